dmem_port_arbiter: RTL

Shares the single byte-write-enabled data-memory BRAM port between two requesters: the CPU memory stage (port 0) and the UART/DMA loader (port 1). Each requester presents word address, 4-bit write mask and pre-aligned write data, as produced by the store-mask stage. The block grants at most one access per cycle and returns a one-cycle-delayed response to the correct requester. It uses fixed CPU priority with a bounded-wait anti-starvation override for the DMA port.

---
 rtl/dmem_port_arbiter_pkg.sv | 26 ++
 rtl/dmem_port_arbiter_if.sv | 26 ++
 rtl/dmem_port_arbiter_rr_wait_counter.sv | 30 +++
 rtl/dmem_port_arbiter.sv | 100 ++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter: port indices, priority
// encoding, response tag layout and the "read = empty write mask" convention.
package dmem_port_arbiter_pkg;

    localparam int   NUM_PORTS = 2;
    localparam int   WE_WIDTH  = 4;
    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_DMA  = 1'b1;

    typedef enum logic {
        PRI_CPU = 1'b0,
        PRI_DMA = 1'b1
    } pri_t;

    typedef struct packed {
        logic pending;
        logic owner;
        logic is_read;
    } rsp_tag_t;

    // An access with no byte lanes enabled is a read.
    function automatic logic is_read(input logic [WE_WIDTH-1:0] we);
        return (we == '0);
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// One requester's view of the shared data-memory port: request handshake
// plus the one-cycle-delayed response.
interface dmem_port_arbiter_if
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  ready;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WE_WIDTH-1:0]   we;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output valid, addr, we, wdata,
        input  ready, rsp_valid, rdata
    );

    modport slave (
        input  valid, addr, we, wdata,
        output ready, rsp_valid, rdata
    );
endinterface

// File: rtl/dmem_port_arbiter_rr_wait_counter.sv
// Saturating count of consecutive blocked cycles for the low-priority port;
// once it reaches MAX_WAIT that port takes priority for the next grant.
module rr_wait_counter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_grant,
    output pri_t       pri,
    output logic [3:0] wait_cnt
);
    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!req_valid || req_grant) begin
            wait_cnt <= '0;
        end else if (wait_cnt != MAX_CNT) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Decoded from the registered count, so grant logic never loops back on itself.
    assign pri = (wait_cnt == MAX_CNT) ? PRI_DMA : PRI_CPU;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one byte-write-enabled BRAM port between the CPU memory stage and the
// DMA loader; fixed CPU priority with a bounded-wait override for DMA.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_port_arbiter_if.slave    cpu,
    dmem_port_arbiter_if.slave    dma,
    output logic                  mem_en,
    output logic [WE_WIDTH-1:0]   mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);
    logic [NUM_PORTS-1:0]  req_valid;
    logic [NUM_PORTS-1:0]  grant;
    logic [ADDR_WIDTH-1:0] req_addr  [NUM_PORTS];
    logic [WE_WIDTH-1:0]   req_we    [NUM_PORTS];
    logic [DATA_WIDTH-1:0] req_wdata [NUM_PORTS];
    logic [NUM_PORTS-1:0]  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata [NUM_PORTS];
    pri_t                  pri;
    logic [3:0]            wait_cnt;
    rsp_tag_t              tag_reg;

    assign req_valid[PORT_CPU] = cpu.valid;
    assign req_addr[PORT_CPU]  = cpu.addr;
    assign req_we[PORT_CPU]    = cpu.we;
    assign req_wdata[PORT_CPU] = cpu.wdata;
    assign req_valid[PORT_DMA] = dma.valid;
    assign req_addr[PORT_DMA]  = dma.addr;
    assign req_we[PORT_DMA]    = dma.we;
    assign req_wdata[PORT_DMA] = dma.wdata;

    rr_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid[PORT_DMA]),
        .req_grant (grant[PORT_DMA]),
        .pri       (pri),
        .wait_cnt  (wait_cnt)
    );

    // A lone requester always wins; contention goes to the priority holder.
    assign grant[PORT_CPU] = req_valid[PORT_CPU] && (!req_valid[PORT_DMA] || pri == PRI_CPU);
    assign grant[PORT_DMA] = req_valid[PORT_DMA] && (!req_valid[PORT_CPU] || pri == PRI_DMA);

    assign cpu.ready = grant[PORT_CPU];
    assign dma.ready = grant[PORT_DMA];

    always_comb begin
        mem_en   = 1'b0;
        mem_we   = '0;
        mem_addr = '0;
        mem_din  = '0;
        if (grant[PORT_CPU]) begin
            mem_en   = 1'b1;
            mem_we   = req_we[PORT_CPU];
            mem_addr = req_addr[PORT_CPU];
            mem_din  = req_wdata[PORT_CPU];
        end else if (grant[PORT_DMA]) begin
            mem_en   = 1'b1;
            mem_we   = req_we[PORT_DMA];
            mem_addr = req_addr[PORT_DMA];
            mem_din  = req_wdata[PORT_DMA];
        end
    end

    // Overwritten every cycle: the BRAM answers exactly one cycle after issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_reg <= '0;
        end else begin
            tag_reg.pending <= |grant;
            tag_reg.owner   <= grant[PORT_DMA] ? PORT_DMA : PORT_CPU;
            tag_reg.is_read <= is_read(mem_we);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_rsp
            assign rsp_valid[gi] = tag_reg.pending && (tag_reg.owner == 1'(gi));
            assign rsp_rdata[gi] = (rsp_valid[gi] && tag_reg.is_read) ? mem_dout : '0;
        end
    endgenerate

    assign cpu.rsp_valid = rsp_valid[PORT_CPU];
    assign cpu.rdata     = rsp_rdata[PORT_CPU];
    assign dma.rsp_valid = rsp_valid[PORT_DMA];
    assign dma.rdata     = rsp_rdata[PORT_DMA];

endmodule
